// File: rtl/bin_bcd_seq_if.sv
// rtl/bin_bcd_seq_if.sv - start/done handshake and result bundle for bin_bcd_seq
interface bin_bcd_seq_if #(
  parameter int BIN_W  = 24,
  parameter int DIGITS = 8
);
  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic [DIGITS-1:0]     lz_mask;
  logic                  ovf;

  modport master (
    output start, bin,
    input  busy, done, bcd, lz_mask, ovf
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, lz_mask, ovf
  );
endinterface

// File: rtl/bin_bcd_seq.sv
// rtl/bin_bcd_seq.sv - sequential double-dabble binary to BCD converter, one bit per clock
module bin_bcd_seq #(
  parameter int BIN_W  = 24,
  parameter int DIGITS = 8,
  parameter int CNT_W  = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  bin_bcd_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_FINISH
  } state_t;

  localparam logic [DIGITS-1:0] LZ_RST = {DIGITS{1'b1}} << 1;

  state_t                r_state;
  logic [BIN_W-1:0]      r_shift;
  logic [4*DIGITS-1:0]   r_dig;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_ovf_acc;
  logic                  r_busy;
  logic                  r_done;
  logic [4*DIGITS-1:0]   r_bcd;
  logic [DIGITS-1:0]     r_lz;
  logic                  r_ovf;

  logic [4*DIGITS-1:0]   w_adj;
  logic [DIGITS-1:0]     w_lz;

  // Add-3 correction per digit; digits are independent, no carry between them.
  always_comb begin
    w_adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_dig[4*i +: 4] >= 4'd5)
        w_adj[4*i +: 4] = r_dig[4*i +: 4] + 4'd3;
      else
        w_adj[4*i +: 4] = r_dig[4*i +: 4];
    end
  end

  // A digit is blanked when it and every digit above it is zero; digit 0 always shows.
  always_comb begin
    logic z;
    z    = 1'b1;
    w_lz = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      z       = z & (r_dig[4*i +: 4] == 4'd0);
      w_lz[i] = z & (i != 0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_dig     <= '0;
      r_cnt     <= '0;
      r_ovf_acc <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_bcd     <= '0;
      r_lz      <= LZ_RST;
      r_ovf     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_shift   <= bus.bin;
            r_dig     <= '0;
            r_ovf_acc <= 1'b0;
            r_cnt     <= CNT_W'(BIN_W);
            r_busy    <= 1'b1;
            r_state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_dig     <= {w_adj[4*DIGITS-2:0], r_shift[BIN_W-1]};
          r_shift   <= r_shift << 1;
          r_ovf_acc <= r_ovf_acc | w_adj[4*DIGITS-1];
          r_cnt     <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1))
            r_state <= S_FINISH;
        end
        S_FINISH: begin
          r_bcd   <= r_dig;
          r_ovf   <= r_ovf_acc;
          r_lz    <= w_lz;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.bcd     = r_bcd;
  assign bus.lz_mask = r_lz;
  assign bus.ovf     = r_ovf;

endmodule

// File: tb/tb_bin_bcd_seq.sv
// tb/tb_bin_bcd_seq.sv - directed bench for bin_bcd_seq, default and 8-bit/2-digit instances
module tb_bin_bcd_seq;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  bin_bcd_seq_if #(.BIN_W(24), .DIGITS(8)) bus0 ();
  bin_bcd_seq_if #(.BIN_W(8),  .DIGITS(2)) bus1 ();

  bin_bcd_seq #(.BIN_W(24), .DIGITS(8), .CNT_W(5)) u0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  bin_bcd_seq #(.BIN_W(8), .DIGITS(2), .CNT_W(4)) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic go0(input logic [23:0] v);
    bus0.start = 1'b1;
    bus0.bin   = v;
    @(posedge clk);
    #1;
    bus0.start = 1'b0;
  endtask

  task automatic wait0(output int cyc, output int bn);
    cyc = 0;
    bn  = bus0.busy ? 1 : 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus0.busy) bn++;
    end while (!bus0.done && cyc < 60);
  endtask

  task automatic go1(input logic [7:0] v, output int cyc);
    bus1.start = 1'b1;
    bus1.bin   = v;
    @(posedge clk);
    #1;
    bus1.start = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!bus1.done && cyc < 40);
  endtask

  initial begin
    int cyc;
    int bn;
    int nd;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus0.start = 1'b0;
    bus0.bin   = '0;
    bus1.start = 1'b0;
    bus1.bin   = '0;

    #23;
    chk("rst_busy", bus0.busy, 0);
    chk("rst_done", bus0.done, 0);
    chk("rst_bcd", bus0.bcd, 0);
    chk("rst_lz", bus0.lz_mask, 8'hFE);
    chk("rst_ovf", bus0.ovf, 0);
    chk("rst_lz_small", bus1.lz_mask, 2'b10);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    go0(24'd0);
    wait0(cyc, bn);
    chk("zero_lat", cyc, 25);
    chk("zero_done", bus0.done, 1);
    chk("zero_bcd", bus0.bcd, 32'h00000000);
    chk("zero_lz", bus0.lz_mask, 8'hFE);
    chk("zero_ovf", bus0.ovf, 0);
    @(posedge clk);
    #1;
    chk("done_pulse", bus0.done, 0);

    go0(24'hFFFFFF);
    wait0(cyc, bn);
    chk("max_lat", cyc, 25);
    chk("max_busy_cycles", bn, 25);
    chk("max_bcd", bus0.bcd, 32'h16777215);
    chk("max_lz", bus0.lz_mask, 8'h00);
    chk("max_ovf", bus0.ovf, 0);

    go0(24'd123456);
    repeat (5) @(posedge clk);
    #1;
    bus0.start = 1'b1;
    bus0.bin   = 24'd999;
    @(posedge clk);
    #1;
    bus0.start = 1'b0;
    wait0(cyc, bn);
    chk("ign_done", bus0.done, 1);
    chk("ign_bcd", bus0.bcd, 32'h00123456);
    chk("ign_lz", bus0.lz_mask, 8'hC0);
    nd = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (bus0.done) nd++;
    end
    chk("ign_no_extra_done", nd, 0);
    chk("ign_bcd_held", bus0.bcd, 32'h00123456);

    bus0.start = 1'b1;
    bus0.bin   = 24'd7;
    @(posedge clk);
    #1;
    bus0.bin = 24'd42;
    wait0(cyc, bn);
    chk("b2b_lat1", cyc, 25);
    chk("b2b_bcd1", bus0.bcd, 32'h00000007);
    chk("b2b_lz1", bus0.lz_mask, 8'hFE);
    wait0(cyc, bn);
    bus0.start = 1'b0;
    chk("b2b_gap", cyc, 26);
    chk("b2b_done2", bus0.done, 1);
    chk("b2b_bcd2", bus0.bcd, 32'h00000042);
    chk("b2b_lz2", bus0.lz_mask, 8'hFC);
    @(posedge clk);
    #1;

    go1(8'd255, cyc);
    chk("small_lat", cyc, 9);
    chk("small255_bcd", bus1.bcd, 8'h55);
    chk("small255_ovf", bus1.ovf, 1);
    chk("small255_lz", bus1.lz_mask, 2'b00);
    go1(8'd99, cyc);
    chk("small99_bcd", bus1.bcd, 8'h99);
    chk("small99_ovf", bus1.ovf, 0);
    go1(8'd5, cyc);
    chk("small5_bcd", bus1.bcd, 8'h05);
    chk("small5_lz", bus1.lz_mask, 2'b10);
    chk("small5_ovf", bus1.ovf, 0);

    go0(24'd500);
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", bus0.busy, 0);
    chk("arst_done", bus0.done, 0);
    chk("arst_bcd", bus0.bcd, 0);
    #10;
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus0.done) nd++;
    end
    chk("arst_no_done", nd, 0);
    go0(24'd9876543);
    wait0(cyc, bn);
    chk("post_rst_lat", cyc, 25);
    chk("post_rst_bcd", bus0.bcd, 32'h09876543);
    chk("post_rst_lz", bus0.lz_mask, 8'h80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
